// File: rtl/timer_mc.sv
// Multi-channel bus-mapped timer with per-channel expiry, one-shot/periodic modes and a masked interrupt.
// Optional per-channel prescaler enabled by defining TIMER_MC_PRESCALER_EN.
module timer_mc #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic        irq
);

    localparam int unsigned SEL_W = 3;
    localparam logic [SEL_W-1:0] GLOBAL_SEL = SEL_W'(7);

    logic              access_c;
    logic              wr_c;
    logic [SEL_W-1:0]  ch_sel_c;
    logic [1:0]        reg_sel_c;

    logic [NUM_CH-1:0] start_q, start_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  expr_q [NUM_CH];
    logic [CNT_W-1:0]  expr_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
`ifdef TIMER_MC_PRESCALER_EN
    logic [CNT_W-1:0]  presc_q [NUM_CH];
    logic [CNT_W-1:0]  presc_d [NUM_CH];
    logic [CNT_W-1:0]  pre_q   [NUM_CH];
    logic [CNT_W-1:0]  pre_d   [NUM_CH];
`endif

    logic [31:0] rd_data_q, rd_data_d;
    logic        rdy_q, rdy_d;
    logic        irq_q, irq_d;
    logic [31:0] rd_mux_c;

    assign access_c  = !cs_ && !as_;
    assign wr_c      = access_c && !rw;
    assign ch_sel_c  = addr[4:2];
    assign reg_sel_c = addr[1:0];

    // Channel counting, expiry and register writes; writes override counter activity.
    always_comb begin : p_next
        logic tick;
        logic expire;
        start_d = start_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        expr_d  = expr_q;
        cnt_d   = cnt_q;
`ifdef TIMER_MC_PRESCALER_EN
        presc_d = presc_q;
        pre_d   = pre_q;
`endif
        pend_d  = pend_q;
        if (wr_c && ch_sel_c == GLOBAL_SEL && reg_sel_c == 2'd0) begin
            pend_d = pend_q & ~wr_data[NUM_CH-1:0];
        end
        if (wr_c && ch_sel_c == GLOBAL_SEL && reg_sel_c == 2'd1) begin
            mask_d = wr_data[NUM_CH-1:0];
        end
        for (int c = 0; c < int'(NUM_CH); c++) begin
            tick   = 1'b0;
            expire = 1'b0;
`ifdef TIMER_MC_PRESCALER_EN
            tick = start_q[c] && (pre_q[c] == presc_q[c]);
            if (start_q[c]) begin
                pre_d[c] = tick ? '0 : pre_q[c] + CNT_W'(1);
            end
`else
            tick = start_q[c];
`endif
            expire = tick && (cnt_q[c] == expr_q[c]);
            if (tick) begin
                cnt_d[c] = expire ? '0 : cnt_q[c] + CNT_W'(1);
            end
            if (expire) begin
                pend_d[c] = 1'b1;
                if (!mode_q[c]) begin
                    start_d[c] = 1'b0;
                end
            end
            if (wr_c && ch_sel_c == SEL_W'(c)) begin
                case (reg_sel_c)
                    2'd0: begin
                        start_d[c] = wr_data[0];
                        mode_d[c]  = wr_data[1];
`ifdef TIMER_MC_PRESCALER_EN
                        if (wr_data[0] && !start_q[c]) begin
                            pre_d[c] = '0;
                        end
`endif
                    end
                    2'd1: expr_d[c] = wr_data[CNT_W-1:0];
                    2'd2: cnt_d[c]  = wr_data[CNT_W-1:0];
`ifdef TIMER_MC_PRESCALER_EN
                    2'd3: presc_d[c] = wr_data[CNT_W-1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    // Read data mux; unmapped locations read as zero.
    always_comb begin
        rd_mux_c = '0;
        if (ch_sel_c == GLOBAL_SEL) begin
            case (reg_sel_c)
                2'd0:    rd_mux_c = 32'(pend_q);
                2'd1:    rd_mux_c = 32'(mask_q);
                default: rd_mux_c = '0;
            endcase
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (ch_sel_c == SEL_W'(c)) begin
                    case (reg_sel_c)
                        2'd0: rd_mux_c = 32'({mode_q[c], start_q[c]});
                        2'd1: rd_mux_c = 32'(expr_q[c]);
                        2'd2: rd_mux_c = 32'(cnt_q[c]);
`ifdef TIMER_MC_PRESCALER_EN
                        2'd3: rd_mux_c = 32'(presc_q[c]);
`endif
                        default: rd_mux_c = '0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        rd_data_d = (access_c && rw) ? rd_mux_c : '0;
        rdy_d     = !access_c;
        irq_d     = |(pend_q & mask_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q   <= '0;
            mode_q    <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            rd_data_q <= '0;
            rdy_q     <= 1'b1;
            irq_q     <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                expr_q[c] <= '0;
                cnt_q[c]  <= '0;
`ifdef TIMER_MC_PRESCALER_EN
                presc_q[c] <= '0;
                pre_q[c]   <= '0;
`endif
            end
        end else begin
            start_q   <= start_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            rd_data_q <= rd_data_d;
            rdy_q     <= rdy_d;
            irq_q     <= irq_d;
            expr_q    <= expr_d;
            cnt_q     <= cnt_d;
`ifdef TIMER_MC_PRESCALER_EN
            presc_q   <= presc_d;
            pre_q     <= pre_d;
`endif
        end
    end

    assign rd_data = rd_data_q;
    assign rdy_    = rdy_q;
    assign irq     = irq_q;

endmodule
